mrelbp_window_gen: RTL and testbench

// - Parametrised streaming KxK sliding-window generator for the MRELBP pipeline.
// - Accepts one raster-order pixel per AXI-Stream beat and buffers WIN-1 image lines.
// - Emits every fully-interior WIN x WIN window, plus its centre pixel, on a

---
 rtl/mrelbp_window_gen.sv | 187 ++++++++++++++++++
 tb/tb_mrelbp_window_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrelbp_window_gen.sv
// Streaming WIN x WIN sliding-window generator: buffers WIN-1 raster lines and
// emits every fully-interior window with its centre pixel on a valid/ready port.
module mrelbp_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 20,
    parameter int IMG_H  = 20,
    parameter int WIN    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [DATA_W-1:0]          s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [WIN*WIN*DATA_W-1:0]  m_window_o,
    output logic [DATA_W-1:0]          m_center_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic                       m_eol_o,
    output logic                       m_last_o,
    output logic                       busy_o,
    output logic                       done_o
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int NLB   = WIN - 1;
    localparam int CTR   = WIN / 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(WIN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(WIN - 1);

    logic [1:0]                  state_reg, state_next;
    logic [COL_W-1:0]            col_reg, col_next, col_inc, rd_addr;
    logic [ROW_W-1:0]            row_reg, row_next;
    logic                        accept, col_wrap, last_pixel, complete, out_fire;

    logic [DATA_W-1:0]           lb_rd    [NLB];
    logic [DATA_W-1:0]           column   [WIN];
    logic [DATA_W-1:0]           win_reg  [WIN][WIN];
    logic [DATA_W-1:0]           win_next [WIN][WIN];
    logic [WIN*WIN*DATA_W-1:0]   win_flat;

    logic [WIN*WIN*DATA_W-1:0]   m_window_reg;
    logic [DATA_W-1:0]           m_center_reg;
    logic                        m_valid_reg, m_eol_reg, m_last_reg;

    genvar gi, gj;

    assign s_axis_tready = (state_reg == S_RUN) && (!m_valid_reg || m_ready_i);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign col_wrap      = (col_reg == COL_LAST);
    assign last_pixel    = col_wrap && (row_reg == ROW_LAST);
    assign complete      = accept && (row_reg >= ROW_FIRST_WIN) && (col_reg >= COL_FIRST_WIN);
    assign out_fire      = m_valid_reg && m_ready_i;
    assign col_inc       = col_wrap ? '0 : col_reg + 1'b1;

    // Read one column ahead on an accept so the registered RAM output already
    // holds the next column's history when its pixel arrives.
    assign rd_addr = accept ? col_inc : col_reg;

    // Bank 0 holds the previous row; each deeper bank takes what the bank above it evicts.
    generate
        for (gi = 0; gi < NLB; gi++) begin : g_lb
            logic [DATA_W-1:0] mem [IMG_W];
            logic [DATA_W-1:0] rd_reg;
            logic [DATA_W-1:0] wr_data;

            if (gi == 0) begin : g_head
                assign wr_data = s_axis_tdata;
            end else begin : g_tail
                assign wr_data = lb_rd[gi-1];
            end

            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[col_reg] <= wr_data;
                end
                rd_reg <= mem[rd_addr];
            end

            assign lb_rd[gi] = rd_reg;
        end
    endgenerate

    // Incoming column, top row first: the oldest line sits in the deepest bank.
    generate
        for (gi = 0; gi < WIN - 1; gi++) begin : g_column
            assign column[gi] = lb_rd[WIN-2-gi];
        end
    endgenerate
    assign column[WIN-1] = s_axis_tdata;

    generate
        for (gi = 0; gi < WIN; gi++) begin : g_row
            for (gj = 0; gj < WIN; gj++) begin : g_col
                if (gj < WIN - 1) begin : g_shift
                    assign win_next[gi][gj] = win_reg[gi][gj+1];
                end else begin : g_load
                    assign win_next[gi][gj] = column[gi];
                end
                assign win_flat[(gi*WIN+gj)*DATA_W +: DATA_W] = win_next[gi][gj];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (accept) begin
            win_reg <= win_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_RUN;
                    col_next   = '0;
                    row_next   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    col_next = col_inc;
                    if (col_wrap) begin
                        row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
                    end
                    if (last_pixel) begin
                        state_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (out_fire && m_last_reg) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            col_reg      <= '0;
            row_reg      <= '0;
            m_valid_reg  <= 1'b0;
            m_window_reg <= '0;
            m_center_reg <= '0;
            m_eol_reg    <= 1'b0;
            m_last_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            // A fresh window overwrites the one being handed off, keeping 1 window/cycle.
            if (complete) begin
                m_valid_reg  <= 1'b1;
                m_window_reg <= win_flat;
                m_center_reg <= win_next[CTR][CTR];
                m_eol_reg    <= col_wrap;
                m_last_reg   <= last_pixel;
            end else if (out_fire) begin
                m_valid_reg  <= 1'b0;
            end
        end
    end

    assign m_window_o = m_window_reg;
    assign m_center_o = m_center_reg;
    assign m_valid_o  = m_valid_reg;
    assign m_eol_o    = m_eol_reg;
    assign m_last_o   = m_last_reg;
    assign busy_o     = (state_reg == S_RUN) || (state_reg == S_FLUSH);
    assign done_o     = (state_reg == S_DONE);

endmodule

// File: tb/tb_mrelbp_window_gen.sv
// Directed bench for mrelbp_window_gen: three instances (3x3/20x20, 7x7/20x20,
// 9x9/9x9) share one driver and one window monitor through a select mux.
module tb_mrelbp_window_gen;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic tvalid;
    logic [7:0] tdata;
    logic m_ready;
    int sel;

    always #5 clk = ~clk;

    logic a_start, a_tvalid, a_tready, a_valid, a_eol, a_last, a_busy, a_done;
    logic b_start, b_tvalid, b_tready, b_valid, b_eol, b_last, b_busy, b_done;
    logic c_start, c_tvalid, c_tready, c_valid, c_eol, c_last, c_busy, c_done;
    logic [71:0]  a_win;
    logic [391:0] b_win;
    logic [647:0] c_win;
    logic [7:0]   a_center, b_center, c_center;

    assign a_start  = start  && (sel == 0);
    assign b_start  = start  && (sel == 1);
    assign c_start  = start  && (sel == 2);
    assign a_tvalid = tvalid && (sel == 0);
    assign b_tvalid = tvalid && (sel == 1);
    assign c_tvalid = tvalid && (sel == 2);

    mrelbp_window_gen #(.DATA_W(8), .IMG_W(20), .IMG_H(20), .WIN(3)) dut_a (
        .clk(clk), .rst(rst), .start_i(a_start),
        .s_axis_tdata(tdata), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
        .m_window_o(a_win), .m_center_o(a_center), .m_valid_o(a_valid),
        .m_ready_i(m_ready), .m_eol_o(a_eol), .m_last_o(a_last),
        .busy_o(a_busy), .done_o(a_done));

    mrelbp_window_gen #(.DATA_W(8), .IMG_W(20), .IMG_H(20), .WIN(7)) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start),
        .s_axis_tdata(tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
        .m_window_o(b_win), .m_center_o(b_center), .m_valid_o(b_valid),
        .m_ready_i(m_ready), .m_eol_o(b_eol), .m_last_o(b_last),
        .busy_o(b_busy), .done_o(b_done));

    mrelbp_window_gen #(.DATA_W(8), .IMG_W(9), .IMG_H(9), .WIN(9)) dut_c (
        .clk(clk), .rst(rst), .start_i(c_start),
        .s_axis_tdata(tdata), .s_axis_tvalid(c_tvalid), .s_axis_tready(c_tready),
        .m_window_o(c_win), .m_center_o(c_center), .m_valid_o(c_valid),
        .m_ready_i(m_ready), .m_eol_o(c_eol), .m_last_o(c_last),
        .busy_o(c_busy), .done_o(c_done));

    logic [647:0] obs_win;
    logic [7:0]   obs_center;
    logic obs_tready, obs_valid, obs_eol, obs_last, obs_busy, obs_done;

    always_comb begin
        obs_win = 648'(a_win); obs_center = a_center; obs_tready = a_tready;
        obs_valid = a_valid; obs_eol = a_eol; obs_last = a_last;
        obs_busy = a_busy; obs_done = a_done;
        case (sel)
            1: begin
                obs_win = 648'(b_win); obs_center = b_center; obs_tready = b_tready;
                obs_valid = b_valid; obs_eol = b_eol; obs_last = b_last;
                obs_busy = b_busy; obs_done = b_done;
            end
            2: begin
                obs_win = c_win; obs_center = c_center; obs_tready = c_tready;
                obs_valid = c_valid; obs_eol = c_eol; obs_last = c_last;
                obs_busy = c_busy; obs_done = c_done;
            end
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [647:0] obs, input logic [647:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [647:0] exp_window(input int iw, input int wn, input int w);
        logic [647:0] res;
        int nw, orow, ocol;
        res  = '0;
        nw   = iw - wn + 1;
        orow = w / nw;
        ocol = w % nw;
        for (int i = 0; i < wn; i++)
            for (int j = 0; j < wn; j++)
                res[(i*wn+j)*8 +: 8] = 8'(((orow + i) * iw + ocol + j) % 256);
        return res;
    endfunction

    function automatic logic [7:0] exp_center(input int iw, input int wn, input int w);
        int nw, orow, ocol;
        nw   = iw - wn + 1;
        orow = w / nw;
        ocol = w % nw;
        return 8'(((orow + wn/2) * iw + ocol + wn/2) % 256);
    endfunction

    // Scoreboard state shared between the monitor and the scenario driver.
    int cur_iw, cur_ih, cur_win, total;
    int mon_count, eol_count, done_count, neg_cnt, last_neg, done_neg, mw;
    logic [7:0]   first_center, last_center;
    logic [647:0] first_win, prev_win;
    logic [7:0]   prev_center;
    logic [1:0]   prev_flags;
    logic         hold_prev = 1'b0;
    logic         exp_eol, exp_last;

    always @(negedge clk) begin
        neg_cnt++;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 648'(obs_valid), 648'(1));
                check("hold_window", obs_win, prev_win);
                check("hold_center", 648'(obs_center), 648'(prev_center));
                check("hold_eol_last", 648'({obs_eol, obs_last}), 648'(prev_flags));
            end
            if (obs_valid && m_ready) begin
                mw       = mon_count;
                exp_eol  = ((mw % (cur_iw - cur_win + 1)) == (cur_iw - cur_win));
                exp_last = (mw == total - 1);
                check("in_range", 648'(mw < total), 648'(1));
                check("window", obs_win, exp_window(cur_iw, cur_win, mw));
                check("center", 648'(obs_center), 648'(exp_center(cur_iw, cur_win, mw)));
                check("eol_last", 648'({obs_eol, obs_last}), 648'({exp_eol, exp_last}));
                if (mw == 0) begin
                    first_center = obs_center;
                    first_win    = obs_win;
                end
                if (obs_eol) eol_count++;
                if (obs_last) begin
                    last_center = obs_center;
                    last_neg    = neg_cnt;
                end
                $display("win %0d center %0d eol %0b last %0b", mw, obs_center, obs_eol, obs_last);
                mon_count++;
            end
            if (obs_done) begin
                done_count++;
                done_neg = neg_cnt;
            end
            hold_prev   = obs_valid && !m_ready;
            prev_win    = obs_win;
            prev_center = obs_center;
            prev_flags  = {obs_eol, obs_last};
        end
    end

    // Streams one frame (pixel value = raster index mod 256). Optional
    // backpressure, a stray start at pixel restart_at, or reset at pixel abort_at.
    task automatic run_frame(input int s, input int iw, input int ih, input int wn,
                             input bit bp, input int restart_at, input int abort_at);
        int  idx, cyc, npix;
        bit  acc, done_seen, restarted, aborted;
        sel = s; cur_iw = iw; cur_ih = ih; cur_win = wn;
        total = (iw - wn + 1) * (ih - wn + 1);
        npix  = iw * ih;
        mon_count = 0; eol_count = 0; done_count = 0; last_neg = -10; done_neg = -20;
        m_ready = 1'b1; tvalid = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_after_start", 648'(obs_busy), 648'(1));
        idx = 0; cyc = 0; done_seen = 0; restarted = 0; aborted = 0;
        while (!done_seen && !aborted && cyc < 5000) begin
            tvalid = (idx < npix) && (!bp || ($urandom_range(0, 3) != 0));
            tdata  = 8'(idx % 256);
            if (bp) m_ready = cyc[0];
            start = 1'b0;
            if (restart_at >= 0 && idx == restart_at && !restarted) begin
                start = 1'b1;
                restarted = 1;
            end
            @(negedge clk);
            acc = tvalid && obs_tready;
            if (obs_done) done_seen = 1;
            else check("busy_running", 648'(obs_busy), 648'(1));
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1; tvalid = 1'b0; start = 1'b0;
                #1;
                check("abort_valid", 648'(obs_valid), 648'(0));
                check("abort_tready", 648'(obs_tready), 648'(0));
                check("abort_busy", 648'(obs_busy), 648'(0));
                check("abort_window", obs_win, 648'(0));
                check("abort_center", 648'(obs_center), 648'(0));
                check("abort_eol_last", 648'({obs_eol, obs_last}), 648'(0));
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                repeat (4) @(posedge clk);
                check("abort_no_done", 648'(done_count), 648'(0));
                aborted = 1;
            end
        end
        tvalid = 1'b0; start = 1'b0; m_ready = 1'b1;
        if (!aborted) begin
            check("frame_timeout", 648'(done_seen), 648'(1));
            repeat (3) @(posedge clk);
            #1;
            check("count", 648'(mon_count), 648'(total));
            check("eol_count", 648'(eol_count), 648'(ih - wn + 1));
            check("done_once", 648'(done_count), 648'(1));
            check("done_latency", 648'(done_neg - last_neg), 648'(1));
            check("idle_busy", 648'(obs_busy), 648'(0));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tvalid = 1'b0; tdata = '0; m_ready = 1'b1; sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready", 648'(obs_tready), 648'(0));
        check("rst_valid", 648'(obs_valid), 648'(0));
        check("rst_window", obs_win, 648'(0));
        check("rst_center", 648'(obs_center), 648'(0));
        check("rst_eol_last", 648'({obs_eol, obs_last}), 648'(0));
        check("rst_busy_done", 648'({obs_busy, obs_done}), 648'(0));
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // 3x3 interior windows, continuous stream
        run_frame(0, 20, 20, 3, 0, -1, -1);
        check("s1_first_window", first_win, 648'(72'h2a_29_28_16_15_14_02_01_00));
        check("s1_first_center", 648'(first_center), 648'(21));
        check("s1_last_center", 648'(last_center), 648'(122));

        // 7x7 row boundaries
        run_frame(1, 20, 20, 7, 0, -1, -1);
        check("s2_count", 648'(mon_count), 648'(196));
        check("s2_first_center", 648'(first_center), 648'(63));
        check("s2_eol_count", 648'(eol_count), 648'(14));

        // backpressure with input gaps
        run_frame(0, 20, 20, 3, 1, -1, -1);
        check("s3_count", 648'(mon_count), 648'(324));
        check("s3_last_center", 648'(last_center), 648'(122));

        // start re-pulsed while busy
        run_frame(0, 20, 20, 3, 0, 50, -1);
        check("s4_count", 648'(mon_count), 648'(324));

        // reset mid-frame, then a clean frame
        run_frame(0, 20, 20, 3, 0, -1, 200);
        run_frame(0, 20, 20, 3, 0, -1, -1);
        check("s5_count", 648'(mon_count), 648'(324));
        check("s5_first_center", 648'(first_center), 648'(21));
        check("s5_last_center", 648'(last_center), 648'(122));

        // minimum image: single 9x9 window
        run_frame(2, 9, 9, 9, 0, -1, -1);
        check("s6_count", 648'(mon_count), 648'(1));
        check("s6_center", 648'(last_center), 648'(40));
        check("s6_eol_count", 648'(eol_count), 648'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
